// File: rtl/store_commit_buffer.sv
// store_commit_buffer: in-order store buffer holding executed stores until ROB commit, then draining to dmem.
// Define STORE_BUF_FWD_EN for store-to-load forwarding; otherwise matching loads are stalled.
module store_commit_buffer #(
    parameter int DEPTH    = 8,
    parameter int GPR_SIZE = 64
) (
    input  logic                in_clk,
    input  logic                in_rst,
    input  logic                in_st_valid,
    input  logic [GPR_SIZE-1:0] in_st_addr,
    input  logic [GPR_SIZE-1:0] in_st_data,
    output logic                out_st_ready,
    input  logic                in_rob_commit_done,
    input  logic                in_rob_commit_is_store,
    input  logic                in_flush,
    input  logic [GPR_SIZE-1:0] in_ld_addr,
    output logic                out_fwd_hit,
    output logic [GPR_SIZE-1:0] out_fwd_value,
    output logic                out_ld_stall,
    output logic                out_dmem_w_enable,
    output logic [GPR_SIZE-1:0] out_dmem_addr,
    output logic [GPR_SIZE-1:0] out_dmem_wval,
    output logic                out_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    logic [GPR_SIZE-1:0] addr_q [DEPTH];
    logic [GPR_SIZE-1:0] data_q [DEPTH];
    logic [PW-1:0] head, cptr, tail, occ, cptr_n;
    logic commit, enq, hit;
    logic [AW-1:0] idx;
    logic unused_ld_lsb;
`ifdef STORE_BUF_FWD_EN
    logic [GPR_SIZE-1:0] fwd_val;
`endif
    assign occ               = tail - head;
    assign out_st_ready      = occ != PW'(DEPTH);
    assign commit            = in_rob_commit_done & in_rob_commit_is_store;
    assign cptr_n            = cptr + PW'(commit && cptr != tail);
    assign enq               = in_st_valid & out_st_ready & ~in_flush;
    assign out_dmem_w_enable = head != cptr;
    assign out_dmem_addr     = out_dmem_w_enable ? addr_q[head[AW-1:0]] : '0;
    assign out_dmem_wval     = out_dmem_w_enable ? data_q[head[AW-1:0]] : '0;
    assign unused_ld_lsb     = ^in_ld_addr[2:0];
    // Flush truncates to the post-commit pointer so a same-cycle commit survives.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            head    <= '0;
            cptr    <= '0;
            tail    <= '0;
            out_err <= 1'b0;
        end else begin
            head <= head + PW'(out_dmem_w_enable);
            cptr <= cptr_n;
            tail <= in_flush ? cptr_n : tail + PW'(enq);
            if (commit && cptr == tail)
                out_err <= 1'b1;
        end
    end
    always_ff @(posedge in_clk) begin
        if (enq) begin
            addr_q[tail[AW-1:0]] <= in_st_addr;
            data_q[tail[AW-1:0]] <= in_st_data;
        end
    end
    // Scan oldest to youngest so the last match is the youngest store.
    always_comb begin
        hit = 1'b0;
        idx = '0;
`ifdef STORE_BUF_FWD_EN
        fwd_val = '0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            idx = head[AW-1:0] + AW'(i);
            if (PW'(i) < occ && addr_q[idx][GPR_SIZE-1:3] == in_ld_addr[GPR_SIZE-1:3]) begin
                hit = 1'b1;
`ifdef STORE_BUF_FWD_EN
                fwd_val = data_q[idx];
`endif
            end
        end
    end
`ifdef STORE_BUF_FWD_EN
    assign out_fwd_hit   = hit;
    assign out_fwd_value = fwd_val;
    assign out_ld_stall  = 1'b0;
`else
    assign out_fwd_hit   = 1'b0;
    assign out_fwd_value = '0;
    assign out_ld_stall  = hit;
`endif
endmodule

// File: doc/store_commit_buffer.md
# store_commit_buffer

In-order store buffer between the load-store reservation station and `dmem`. Executed stores are held until the ROB commits them, then drained to `dmem` one per cycle. A mispredict flush discards only the uncommitted stores, so speculative stores never reach memory. Loads snoop the buffer and receive the youngest matching store value (store-to-load forwarding).

## Interface
Parameters:
- `DEPTH`, 8: number of entries; power of two, at least 2.
- `GPR_SIZE`, 64: address and data width.

Ports:
- `in_clk`, input, 1: clock, rising edge.
- `in_rst`, input, 1: reset, asynchronous, active-high.
- `in_st_valid`, input, 1: an executed store is presented for enqueue.
- `in_st_addr`, input, GPR_SIZE: store address. Must be 8-byte aligned.
- `in_st_data`, input, GPR_SIZE: store data.
- `out_st_ready`, output, 1: buffer can accept a store this cycle.
- `in_rob_commit_done`, input, 1: the ROB retires an instruction this cycle.
- `in_rob_commit_is_store`, input, 1: the retiring instruction is a store.
- `in_flush`, input, 1: mispredict; discard all uncommitted entries.
- `in_ld_addr`, input, GPR_SIZE: address of the load being looked up.
- `out_fwd_hit`, output, 1: a buffered store matches `in_ld_addr`.
- `out_fwd_value`, output, GPR_SIZE: data of the youngest matching store.
- `out_ld_stall`, output, 1: the load must wait. Used only in the no-forwarding build.
- `out_dmem_w_enable`, output, 1: write the head entry to `dmem` this cycle.
- `out_dmem_addr`, output, GPR_SIZE: address for the `dmem` write.
- `out_dmem_wval`, output, GPR_SIZE: data for the `dmem` write.
- `out_err`, output, 1: sticky error. Set when a store commit arrives with no uncommitted entry.

## Operation
- Storage: circular array of `DEPTH` entries, each holding `{addr, data}`.
- Pointers, each `$clog2(DEPTH)+1` bits with a wrap bit:
  - `head`: oldest entry.
  - `cptr`: first uncommitted entry.
  - `tail`: next free slot.
- Invariant: `head <= cptr <= tail` in circular order. Occupancy is `tail - head`, at most `DEPTH`.
- Enqueue: when `in_st_valid & out_st_ready & ~in_flush`, write the entry at `tail` and increment `tail`.
- `out_st_ready = (tail - head) != DEPTH`. It depends only on registered state.
- Commit: when `in_rob_commit_done & in_rob_commit_is_store`:
  - If `cptr != tail`, increment `cptr`.
  - Otherwise set `out_err` and leave `cptr` unchanged.
- Drain:
  - `out_dmem_w_enable = (head != cptr)`.
  - `out_dmem_addr` / `out_dmem_wval` carry the head entry.
  - `head` increments on every cycle `out_dmem_w_enable` is 1.
  - When `out_dmem_w_enable` is 0, addr/wval are 0.
- Flush: `tail <= cptr'`, where `cptr'` is `cptr` after this cycle's commit. Committed entries keep draining.
- Forwarding lookup:
  - Candidates: all valid entries from `head` to `tail-1`, committed or not.
  - Match on `addr[GPR_SIZE-1:3]`.
  - The youngest match (closest to `tail`) wins.
  - With no match: `out_fwd_hit = 0`, `out_fwd_value = 0`.
- Simultaneous events within one cycle, in priority order:
  1. Commit is evaluated first.
  2. Flush then truncates `tail`.
  3. An enqueue in a flush cycle is dropped.
  4. Drain of the head proceeds independently.
- Enqueue, commit and drain may all occur in the same cycle.
- Full buffer: enqueue is refused via `out_st_ready = 0`. A drain in the same cycle does not make the buffer ready until the next cycle.

## Timing
- Reset, asynchronous: `head`, `cptr`, `tail` = 0 and `out_err` = 0. Every output is then 0 except `out_st_ready`, which is 1.
- Reset mid-operation drops all entries, committed ones included.
- Enqueue-to-lookup visibility: 1 cycle. A store enqueued at edge N is forwardable in cycle N+1. A same-cycle enqueue is not visible.
- Commit-to-drain: a commit at edge N makes `out_dmem_w_enable` 1 in cycle N+1 if that entry is now the head. The `dmem` write completes at edge N+2.
- Drain throughput: 1 store per cycle.
- An entry draining in a cycle is still a forwarding candidate in that cycle.
- Lookup outputs are combinational from `in_ld_addr` and registered state, with zero latency.
- `out_err` stays set until reset.

## Configuration
- `STORE_BUF_FWD_EN` defined:
  - Forwarding logic is present as described.
  - `out_ld_stall` is tied to 0.
- `STORE_BUF_FWD_EN` undefined:
  - No forwarding mux is built.
  - `out_fwd_hit` and `out_fwd_value` are tied to 0.
  - `out_ld_stall = 1` whenever any valid entry matches `in_ld_addr[GPR_SIZE-1:3]`. The load RS then holds the load until that store drains.

## Test plan
- Basic store flow, `DEPTH`=8:
  - Enqueue store (0x40, 0xDEAD); commit it 3 cycles later.
  - `out_dmem_w_enable` goes to 1 for exactly 1 cycle, the cycle after the commit, with addr 0x40 and wval 0xDEAD. The buffer is then empty.
- Fill to 8 entries:
  - `out_st_ready` goes to 0 and a 9th enqueue is ignored.
  - Commit one store: it drains, then `out_st_ready` returns to 1.
- Mispredict flush:
  - Enqueue 4 stores, commit 2, assert `in_flush`.
  - Exactly 2 `dmem` writes occur, in order. After the flush, `tail == cptr`.
  - An enqueue asserted in the flush cycle is dropped.
- Forwarding, with `STORE_BUF_FWD_EN` defined:
  - Enqueue (0x80, 1) then (0x80, 2); look up 0x80. Expect `out_fwd_hit` = 1 and value 2.
  - Look up 0x88. Expect hit = 0.
  - Without the macro, a lookup of 0x80 gives `out_ld_stall` = 1 until both stores drain.
- Commit error and wrap-around:
  - Store commit with the buffer empty: `out_err` = 1 and stays set.
  - Stream 20 stores, each committed one cycle after enqueue: all 20 `dmem` writes occur in order across the pointer wrap.
- Reset mid-operation:
  - Assert `in_rst` asynchronously while 3 committed entries are draining.
  - All outputs reset immediately and no further `dmem` writes occur.
